// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the 16-bit multi-cycle processor.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             flag_zero,
  input  logic             flag_negative,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic             PCSrc,
  output logic             pc_write,
  output logic             IorD,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT, S_FAULT
  } state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic rtype_q, rtype_d, retire, tmo;
  assign tmo = !mem_ready && (wait_q == WW'(MEM_TIMEOUT - 1));
  assign instr_retired = cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q <= '0;
      rtype_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      rtype_q <= rtype_d;
      cnt_q <= cnt_q + CNT_W'(retire);
    end
  end
  always_comb begin
    state_d = state_q;
    rtype_d = rtype_q;
    retire = 1'b0;
    ALUSrcA = 2'd0;
    ALUSrcB = 2'd0;
    ALUOp = 4'd0;
    PCSrc = 1'b0;
    pc_write = 1'b0;
    IorD = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    illegal_op = 1'b0;
    halted = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB = 2'd1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : tmo ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut <= PC + imm, the branch target used later by BRANCH
        ALUSrcB = 2'd2;
        illegal_op = opcode inside {[4'hB:4'hE]};
        retire = illegal_op || opcode == 4'hF;
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC_R;
          4'h4: state_d = S_EXEC_I;
          4'h5, 4'h6: state_d = S_MEM_ADDR;
          4'h7, 4'h8, 4'h9: state_d = S_BRANCH;
          4'hA: state_d = S_JUMP;
          4'hF: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 2'd2;
        ALUOp = {2'b00, opcode[1:0]};
        rtype_d = 1'b1;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
        rtype_d = 1'b0;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst = rtype_q;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
        state_d = opcode == 4'h5 ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        IorD = 1'b1;
        mem_read = 1'b1;
        state_d = mem_ready ? S_MEM_WB : tmo ? S_FAULT : S_MEM_READ;
      end
      S_MEM_WRITE: begin
        IorD = 1'b1;
        mem_write = 1'b1;
        retire = mem_ready;
        state_d = mem_ready ? S_FETCH : tmo ? S_FAULT : S_MEM_WRITE;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'd2;
        ALUOp = 4'd1;
        PCSrc = 1'b1;
        pc_write = opcode == 4'h7 ? flag_zero : opcode == 4'h8 ? !flag_zero : flag_negative;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ALUSrcA = 2'd3;
        ALUOp = 4'hF;
        pc_write = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_FAULT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // the wait counter restarts whenever a new state is entered
    wait_d = (state_d != state_q) ? '0 : wait_q + WW'(!mem_ready);
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, random instruction stream and corner sequences for multicycle_control.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset, mem_ready, flag_zero, flag_negative;
  logic [3:0] opcode;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp;
  logic PCSrc, pc_write, IorD, mem_read, mem_write, ir_write, reg_write, mem_to_reg, reg_dst, illegal_op, halted;
  logic [15:0] instr_retired;
  logic [18:0] got;
  int n_cmp = 0, n_err = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .flag_zero(flag_zero), .flag_negative(flag_negative),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .pc_write(pc_write), .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .illegal_op(illegal_op), .halted(halted),
    .instr_retired(instr_retired)
  );

  assign got = {ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_write, IorD, mem_read, mem_write,
                ir_write, reg_write, mem_to_reg, reg_dst, illegal_op, halted};

  function automatic logic [18:0] sel(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op, input logic pcs);
    return {a, b, op, pcs, 10'b0};
  endfunction

  localparam logic [18:0] PCW = 19'd1 << 9, IORD = 19'd1 << 8, MR = 19'd1 << 7, MW = 19'd1 << 6;
  localparam logic [18:0] IRW = 19'd1 << 5, RW = 19'd1 << 4, M2R = 19'd1 << 3, RD = 19'd1 << 2;
  localparam logic [18:0] ILL = 19'd1 << 1, HLT = 19'd1;
  localparam logic [18:0] F_WAIT = sel(2'd0, 2'd1, 4'd0, 1'b0) | MR;
  localparam logic [18:0] F_GO = F_WAIT | IRW | PCW;
  localparam logic [18:0] DEC = sel(2'd0, 2'd2, 4'd0, 1'b0);
  localparam logic [18:0] EXI = sel(2'd2, 2'd2, 4'd0, 1'b0);
  localparam logic [18:0] MADDR = EXI;
  localparam logic [18:0] MRD = IORD | MR, MWR = IORD | MW, MWB = RW | M2R;
  localparam logic [18:0] BR = sel(2'd2, 2'd0, 4'd1, 1'b1);
  localparam logic [18:0] JMP = sel(2'd3, 2'd0, 4'd15, 1'b0) | PCW;

  typedef struct {
    logic mr;
    logic [3:0] op;
    logic fz;
    logic fn;
    logic [18:0] exp;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic chk(input logic [18:0] exp, input string nm);
    n_cmp++;
    if (got !== exp || instr_retired !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s: got ctl=%h cnt=%0d, want ctl=%h cnt=%0d", nm, got, instr_retired, exp, 16'(exp_cnt));
    end
  endtask

  task automatic cyc(input logic mr, input logic [18:0] exp, input string nm);
    mem_ready = mr;
    @(negedge clk);
    chk(exp, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk('0, "reset_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(rnd(), '0, "reset_idle");
  endtask

  task automatic add(input logic mr, input logic [3:0] op, input logic fz, input logic fn, input logic [18:0] exp, input int cnt);
    tbl.push_back('{mr, op, fz, fn, exp, cnt});
  endtask

  // reference: one instruction, expected controls derived from its opcode class
  task automatic do_instr(input logic [3:0] op, input int fs, input int ms, input logic fz, input logic fn);
    logic tk;
    opcode = 4'($urandom);
    flag_zero = fz;
    flag_negative = fn;
    for (int i = 0; i < fs; i++) cyc(1'b0, F_WAIT, "fetch_wait");
    cyc(1'b1, F_GO, "fetch");
    opcode = op;
    if (op inside {[4'hB:4'hE]}) begin
      cyc(rnd(), DEC | ILL, "decode_illegal");
      exp_cnt++;
      return;
    end
    cyc(rnd(), DEC, "decode");
    if (op <= 4'd3) begin
      cyc(rnd(), sel(2'd2, 2'd0, {2'b00, op[1:0]}, 1'b0), "exec_r");
      cyc(rnd(), RW | RD, "wb_r");
    end else if (op == 4'd4) begin
      cyc(rnd(), EXI, "exec_i");
      cyc(rnd(), RW, "wb_i");
    end else if (op == 4'd5 || op == 4'd6) begin
      cyc(rnd(), MADDR, "mem_addr");
      for (int i = 0; i < ms; i++) cyc(1'b0, op == 4'd5 ? MRD : MWR, "mem_wait");
      cyc(1'b1, op == 4'd5 ? MRD : MWR, "mem_done");
      if (op == 4'd5) cyc(rnd(), MWB, "mem_wb");
    end else if (op <= 4'd9) begin
      tk = op == 4'd7 ? fz : op == 4'd8 ? !fz : fn;
      cyc(rnd(), BR | (tk ? PCW : 19'd0), "branch");
    end else begin
      cyc(rnd(), JMP, "jump");
    end
    exp_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 4'd0;
    flag_zero = 1'b0;
    flag_negative = 1'b0;
    add(1, 4'h0, 0, 0, F_GO, 0); add(1, 4'h0, 0, 0, DEC, 0);
    add(1, 4'h0, 0, 0, sel(2'd2, 2'd0, 4'd0, 1'b0), 0); add(1, 4'h0, 0, 0, RW | RD, 0);
    add(1, 4'h3, 0, 0, F_GO, 1); add(1, 4'h3, 0, 0, DEC, 1);
    add(1, 4'h3, 0, 0, sel(2'd2, 2'd0, 4'd3, 1'b0), 1); add(1, 4'h3, 0, 0, RW | RD, 1);
    add(1, 4'h4, 0, 0, F_GO, 2); add(1, 4'h4, 0, 0, DEC, 2);
    add(1, 4'h4, 0, 0, EXI, 2); add(1, 4'h4, 0, 0, RW, 2);
    add(1, 4'h7, 1, 0, F_GO, 3); add(1, 4'h7, 1, 0, DEC, 3); add(1, 4'h7, 1, 0, BR | PCW, 3);
    add(1, 4'h8, 1, 0, F_GO, 4); add(1, 4'h8, 1, 0, DEC, 4); add(1, 4'h8, 1, 0, BR, 4);
    add(1, 4'h9, 0, 1, F_GO, 5); add(1, 4'h9, 0, 1, DEC, 5); add(1, 4'h9, 0, 1, BR | PCW, 5);
    add(1, 4'h9, 1, 0, F_GO, 6); add(1, 4'h9, 1, 0, DEC, 6); add(1, 4'h9, 1, 0, BR, 6);
    add(1, 4'hA, 0, 0, F_GO, 7); add(1, 4'hA, 0, 0, DEC, 7); add(1, 4'hA, 0, 0, JMP, 7);
    add(1, 4'h6, 0, 0, F_GO, 8); add(1, 4'h6, 0, 0, DEC, 8);
    add(1, 4'h6, 0, 0, MADDR, 8); add(1, 4'h6, 0, 0, MWR, 8);
    add(1, 4'h5, 0, 0, F_GO, 9); add(1, 4'h5, 0, 0, DEC, 9); add(1, 4'h5, 0, 0, MADDR, 9);
    add(1, 4'h5, 0, 0, MRD, 9); add(1, 4'h5, 0, 0, MWB, 9);
    #2;
    do_reset();
    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      flag_zero = tbl[i].fz;
      flag_negative = tbl[i].fn;
      exp_cnt = tbl[i].cnt;
      cyc(tbl[i].mr, tbl[i].exp, $sformatf("vec%0d", i));
    end
    exp_cnt = 10;
    for (int n = 0; n < 60; n++)
      do_instr(4'($urandom_range(0, 14)), $urandom_range(0, 4), $urandom_range(0, 4), rnd(), rnd());
    do_instr(4'h5, 0, 3, 1'b0, 1'b0);
    do_instr(4'hC, 0, 0, 1'b0, 1'b0);
    do_instr(4'h0, 15, 0, 1'b0, 1'b0);
    do_instr(4'h6, 0, 15, 1'b0, 1'b0);
    // reset in the middle of a stalled load
    opcode = 4'h5;
    cyc(1'b1, F_GO, "lw_fetch");
    cyc(1'b1, DEC, "lw_decode");
    cyc(1'b1, MADDR, "lw_addr");
    cyc(1'b0, MRD, "lw_wait");
    do_reset();
    do_instr(4'h0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, F_WAIT, "fetch_timeout_wait");
    for (int i = 0; i < 3; i++) cyc(rnd(), HLT, "fault_fetch");
    do_reset();
    opcode = 4'h6;
    cyc(1'b1, F_GO, "sw_fetch");
    cyc(1'b1, DEC, "sw_decode");
    cyc(1'b1, MADDR, "sw_addr");
    for (int i = 0; i < 16; i++) cyc(1'b0, MWR, "sw_timeout_wait");
    for (int i = 0; i < 2; i++) cyc(rnd(), HLT, "fault_sw");
    do_reset();
    do_instr(4'h4, 0, 0, 1'b0, 1'b0);
    opcode = 4'hF;
    cyc(1'b1, F_GO, "halt_fetch");
    cyc(1'b1, DEC, "halt_decode");
    exp_cnt++;
    for (int i = 0; i < 4; i++) cyc(1'(i), HLT, "halted");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM of the 16-bit multi-cycle processor. Decodes the latched instruction opcode and sequences every datapath select and enable, including the ALU-stage selects (ALU source muxes, ALU op, PC source) and the register, memory and PC write enables, one state per cycle. It sits upstream of the calculation stage and consumes that stage's combinational Zero/Negative flags to resolve branches in the same cycle.

Parameters:
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in a memory state before aborting to FAULT.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
opcode  in  4  IR[15:12], valid from DECODE onward.
mem_ready  in  1  memory handshake; 1 = access completes this cycle.
flag_zero  in  1  combinational ALU Zero flag.
flag_negative  in  1  combinational ALU Negative flag.
ALUSrcA  out  2  0=PC, 1=const 1, 2=A reg, 3=imm.
ALUSrcB  out  2  0=B reg, 1=const 1, 2=imm.
ALUOp  out  4  0=ADD, 1=SUB, 2=AND, 3=OR, 15=PASS_A.
PCSrc  out  1  0=ALU result, 1=ALUOut register.
pc_write  out  1  PC load enable, with branch condition already applied.
IorD  out  1  0=PC address, 1=ALUOut address.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
ir_write  out  1  instruction register load.
reg_write  out  1  register file write.
mem_to_reg  out  1  write-back select: 0=ALUOut, 1=MDR.
reg_dst  out  1  destination field: 0=rt (I-type), 1=rd (R-type).
illegal_op  out  1  one-cycle pulse on an undefined opcode.
halted  out  1  high in HALT or FAULT.
instr_retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI; 5 LW; 6 SW; 7 BEQ; 8 BNE; 9 BLT; A JMP; F HALT. Opcodes B–E are undefined.
- States: RESET_IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT, FAULT.
- Outputs are a Moore decode of the state register, except pc_write in BRANCH, which is Mealy on the flags. Every enable not listed for a state is 0.
- Reset asserted at any time, including mid-instruction: state=RESET_IDLE, instr_retired=0, all outputs 0. An in-flight instruction is discarded. One cycle after reset deasserts, the FSM goes to FETCH.
- FETCH: mem_read=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSrc=0. While mem_ready=0 the FSM holds here and ir_write and pc_write stay 0. When mem_ready=1, ir_write=1 and pc_write=1 (PC<=PC+1), and the FSM moves to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=2, ADD, which precomputes the branch target PC+imm into ALUOut. Next state by opcode: 0–3 EXEC_R; 4 EXEC_I; 5/6 MEM_ADDR; 7–9 BRANCH; A JUMP; F HALT; B–E pulse illegal_op, increment instr_retired, return to FETCH.
- EXEC_R: ALUSrcA=2, ALUSrcB=0, ALUOp=opcode[1:0] zero-extended. Next: WB_ALU.
- EXEC_I: ALUSrcA=2, ALUSrcB=2, ADD. Next: WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 when entered from EXEC_R and 0 when entered from EXEC_I (the R/I-type origin is held in a flop). Retires; next FETCH.
- MEM_ADDR: ALUSrcA=2, ALUSrcB=2, ADD. Next: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ and MEM_WRITE: IorD=1 with mem_read=1 or mem_write=1, held until mem_ready=1. MEM_READ then goes to MEM_WB. MEM_WRITE retires and goes to FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires; next FETCH.
- BRANCH: ALUSrcA=2, ALUSrcB=0, SUB, PCSrc=1. pc_write = flag_zero for BEQ, !flag_zero for BNE, flag_negative for BLT. Retires; next FETCH.
- JUMP: ALUSrcA=3, ALUOp=PASS_A, PCSrc=0, pc_write=1. Retires; next FETCH.
- Timeout: a wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT, the FSM goes to FAULT with no write issued.
- HALT and FAULT are terminal until reset; halted=1. HALT retires once on entry; FAULT does not retire.
- Latency with mem_ready tied 1: R/ADDI 4 cycles, LW 5, SW 4, branch/jump 3, undefined 2.

Test Plan:
- Reset: reset=0 mid-LW in MEM_READ -> next edge: all outputs 0, instr_retired=0; after release, FETCH with mem_read=1 one cycle later.
- ADD (opcode 0), mem_ready=1 -> 4 cycles FETCH/DECODE/EXEC_R/WB_ALU; EXEC_R shows ALUSrcA=2, ALUSrcB=0, ALUOp=0; WB_ALU shows reg_write=1, reg_dst=1; instr_retired 0->1.
- LW with mem_ready low for 3 cycles in MEM_READ -> IorD=1 and mem_read=1 held for 4 cycles, then MEM_WB with reg_write=1, mem_to_reg=1; total 8 cycles.
- BEQ with flag_zero=1, then BNE with flag_zero=1 -> BEQ gives pc_write=1 with PCSrc=1 in BRANCH; BNE gives pc_write=0; both retire.
- Opcode C -> illegal_op pulses one cycle in DECODE, then FETCH; opcode F -> halted=1 and stays there with mem_ready toggling.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> FAULT after 16 cycles, halted=1, ir_write never asserted, instr_retired unchanged.
